// File: rtl/pipeline_stall_ctrl.sv
// Hazard/stall controller for the 5-stage pipeline: load-use, multi-cycle divide, memory wait, branch flush.
// Optional performance counters are compiled in when STALL_PERF_CNT_EN is defined.
module pipeline_stall_ctrl #(
  parameter int DIV_CYCLES = 32,
  parameter int CNT_W      = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_use_rs,
  input  logic       id_use_rt,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rt,
  input  logic       ex_div_start,
  input  logic       mem_wait,
  input  logic       id_branch_taken,
  output logic [5:0] stall,
  output logic       div_busy,
  output logic       div_done
`ifdef STALL_PERF_CNT_EN
  ,
  output logic [31:0] perf_stall_cycles,
  output logic [31:0] perf_flush_count
`endif
);

  typedef enum logic {
    IDLE     = 1'b0,
    DIV_BUSY = 1'b1
  } fsm_t;

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DIV_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  fsm_t             fsm_reg, fsm_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             load_use;
  logic             div_active;

  assign load_use = ex_mem_read && (ex_rt != 5'd0) &&
                    ((id_use_rs && (id_rs == ex_rt)) || (id_use_rt && (id_rt == ex_rt)));

  // A divide stalls from the very first cycle it is seen in EX, before the FSM leaves IDLE.
  assign div_active = ((fsm_reg == IDLE) && ex_div_start) || (fsm_reg == DIV_BUSY);

  always_ff @(posedge clk) begin
    if (reset) begin
      fsm_reg <= IDLE;
      cnt_reg <= '0;
    end else begin
      fsm_reg <= fsm_next;
      cnt_reg <= cnt_next;
    end
  end

  always_comb begin
    fsm_next = fsm_reg;
    cnt_next = cnt_reg;
    stall    = 6'b000000;
    div_busy = 1'b0;
    div_done = 1'b0;
    if (!reset) begin
      div_busy = div_active;
      if (mem_wait)
        stall = 6'b011111;
      else if (div_active)
        stall = 6'b001111;
      else if (load_use)
        stall = 6'b000111;
      else if (id_branch_taken)
        stall = 6'b000010;

      // A memory wait freezes the divide sequence, stretching it by one cycle per wait.
      if (!mem_wait) begin
        unique case (fsm_reg)
          IDLE: begin
            if (ex_div_start) begin
              fsm_next = DIV_BUSY;
              cnt_next = CNT_LOAD;
            end
          end
          DIV_BUSY: begin
            if (cnt_reg > CNT_ONE) begin
              cnt_next = cnt_reg - CNT_ONE;
            end else begin
              fsm_next = IDLE;
              cnt_next = '0;
              div_done = 1'b1;
            end
          end
          default: begin
            fsm_next = IDLE;
            cnt_next = '0;
          end
        endcase
      end
    end
  end

`ifdef STALL_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_stall_cycles <= '0;
      perf_flush_count  <= '0;
    end else begin
      if (stall != 6'b000000)
        perf_stall_cycles <= perf_stall_cycles + 32'd1;
      if (stall == 6'b000010)
        perf_flush_count <= perf_flush_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Self-checking bench for pipeline_stall_ctrl: directed scenarios followed by randomized traffic
// compared cycle by cycle against a remaining-cycles model of the hazard rules.
module tb_pipeline_stall_ctrl;

  localparam int DIV_CYCLES = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] id_rs, id_rt, ex_rt;
  logic       id_use_rs, id_use_rt, ex_mem_read, ex_div_start, mem_wait, id_branch_taken;
  logic [5:0] stall;
  logic       div_busy, div_done;
`ifdef STALL_PERF_CNT_EN
  logic [31:0] perf_stall_cycles, perf_flush_count;
`endif

  pipeline_stall_ctrl #(.DIV_CYCLES(DIV_CYCLES), .CNT_W(8)) dut (
    .clk             (clk),
    .reset           (reset),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .id_use_rs       (id_use_rs),
    .id_use_rt       (id_use_rt),
    .ex_mem_read     (ex_mem_read),
    .ex_rt           (ex_rt),
    .ex_div_start    (ex_div_start),
    .mem_wait        (mem_wait),
    .id_branch_taken (id_branch_taken),
    .stall           (stall),
    .div_busy        (div_busy),
    .div_done        (div_done)
`ifdef STALL_PERF_CNT_EN
    ,
    .perf_stall_cycles (perf_stall_cycles),
    .perf_flush_count  (perf_flush_count)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: number of divide stall cycles still owed (0 = no divide in flight).
  int          div_left = 0;
  int unsigned m_stall_cycles = 0;
  int unsigned m_flush_count  = 0;
  logic [5:0]  m_stall;
  logic        m_busy, m_done;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit hazard();
    return ex_mem_read && ex_rt != 0 &&
           ((id_use_rs && id_rs == ex_rt) || (id_use_rt && id_rt == ex_rt));
  endfunction

  task automatic model_eval();
    bit active;
    active  = (div_left > 0) || ex_div_start;
    m_stall = 6'd0;
    m_busy  = 1'b0;
    m_done  = 1'b0;
    if (!reset) begin
      m_busy = active;
      m_done = !mem_wait && div_left == 1;
      if (mem_wait)             m_stall = 6'b011111;
      else if (active)          m_stall = 6'b001111;
      else if (hazard())        m_stall = 6'b000111;
      else if (id_branch_taken) m_stall = 6'b000010;
    end
  endtask

  task automatic model_update();
    if (reset) begin
      div_left       = 0;
      m_stall_cycles = 0;
      m_flush_count  = 0;
    end else begin
      if (!mem_wait && (div_left > 0 || ex_div_start)) begin
        if (div_left == 0) div_left = DIV_CYCLES;
        div_left--;
      end
      if (m_stall != 0)          m_stall_cycles++;
      if (m_stall == 6'b000010)  m_flush_count++;
    end
  endtask

  // One clock cycle: inputs are already driven; check outputs mid-cycle, then advance the model.
  task automatic cyc(input string tag, input bit lit, input logic [5:0] exp_stall, input bit exp_done);
    #3;
    model_eval();
    check({tag, "_stall"}, 32'(stall), 32'(m_stall));
    check({tag, "_busy"}, 32'(div_busy), 32'(m_busy));
    check({tag, "_done"}, 32'(div_done), 32'(m_done));
`ifdef STALL_PERF_CNT_EN
    check({tag, "_pstall"}, perf_stall_cycles, m_stall_cycles);
    check({tag, "_pflush"}, perf_flush_count, m_flush_count);
`endif
    if (lit) begin
      check({tag, "_stall_lit"}, 32'(stall), 32'(exp_stall));
      check({tag, "_done_lit"}, 32'(div_done), 32'(exp_done));
    end
    $display("cycle %-10s stall=%b busy=%b done=%b", tag, stall, div_busy, div_done);
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle_inputs();
    reset = 0; id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0;
    ex_mem_read = 0; ex_rt = 0; ex_div_start = 0; mem_wait = 0; id_branch_taken = 0;
  endtask

  task automatic set_load_use();
    ex_mem_read = 1; ex_rt = 5; id_use_rs = 1; id_rs = 5;
  endtask

  initial begin
    @(posedge clk); #1;
    // Reset with every input active
    reset = 1; id_rs = 7; id_rt = 7; id_use_rs = 1; id_use_rt = 1;
    ex_mem_read = 1; ex_rt = 7; ex_div_start = 1; mem_wait = 1; id_branch_taken = 1;
    cyc("rst0", 1, 6'b000000, 0);
    cyc("rst1", 1, 6'b000000, 0);
    idle_inputs();
    cyc("idle", 1, 6'b000000, 0);

    set_load_use();
    cyc("lu", 1, 6'b000111, 0);
    ex_rt = 0; id_rs = 0;
    cyc("lu_r0", 1, 6'b000000, 0);
    idle_inputs();

    ex_div_start = 1;
    for (int i = 1; i <= DIV_CYCLES; i++)
      cyc($sformatf("div%0d", i), 1, 6'b001111, i == DIV_CYCLES);
    ex_div_start = 0;
    cyc("div_end", 1, 6'b000000, 0);

    // Divide stretched by two memory-wait cycles
    ex_div_start = 1;
    cyc("dw1", 1, 6'b001111, 0);
    mem_wait = 1;
    cyc("dw2", 1, 6'b011111, 0);
    cyc("dw3", 1, 6'b011111, 0);
    mem_wait = 0;
    cyc("dw4", 1, 6'b001111, 0);
    cyc("dw5", 1, 6'b001111, 0);
    cyc("dw6", 1, 6'b001111, 1);
    ex_div_start = 0;
    cyc("dw_end", 1, 6'b000000, 0);

    id_branch_taken = 1;
    cyc("br", 1, 6'b000010, 0);
    set_load_use();
    cyc("br_lu", 1, 6'b000111, 0);
    idle_inputs(); id_branch_taken = 1; mem_wait = 1;
    cyc("br_mw", 1, 6'b011111, 0);
    idle_inputs();

    // Reset in the middle of a divide drops the stall immediately
    ex_div_start = 1;
    cyc("dr1", 1, 6'b001111, 0);
    ex_div_start = 0; reset = 1;
    cyc("dr_rst", 1, 6'b000000, 0);
    reset = 0;
    cyc("dr_after", 1, 6'b000000, 0);

`ifdef STALL_PERF_CNT_EN
    reset = 1;
    cyc("p_rst", 0, 6'b0, 0);
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      id_branch_taken = 1;
      cyc("p_br", 1, 6'b000010, 0);
      idle_inputs();
      cyc("p_gap", 0, 6'b0, 0);
    end
    set_load_use();
    cyc("p_lu", 1, 6'b000111, 0);
    idle_inputs();
    cyc("p_end", 0, 6'b0, 0);
    check("perf_flush_lit", perf_flush_count, 32'd3);
    check("perf_stall_lit", perf_stall_cycles, 32'd4);
`endif

    // Randomized traffic; small register numbers make hazards frequent.
    for (int i = 0; i < 1500; i++) begin
      reset           = ($urandom_range(0, 59) == 0);
      id_rs           = 5'($urandom_range(0, 3));
      id_rt           = 5'($urandom_range(0, 3));
      id_use_rs       = 1'($urandom);
      id_use_rt       = 1'($urandom);
      ex_mem_read     = ($urandom_range(0, 2) == 0);
      ex_rt           = 5'($urandom_range(0, 3));
      mem_wait        = ($urandom_range(0, 5) == 0);
      id_branch_taken = ($urandom_range(0, 3) == 0);
      if (div_left > 0) ex_div_start = 1;
      else              ex_div_start = ($urandom_range(0, 19) == 0);
      cyc("rnd", 0, 6'b0, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
